// File: rtl/vector_pair_packer_pkg.sv
// vector_pair_packer_pkg
//   Shared definitions for the vector pair packer slice.
//   - state_t      : packer FSM states (FILL collects lanes, HOLD presents a pair)
//   - DEFAULT_W    : default element width used by the dot product datapath
//   - DEFAULT_N    : default number of lanes per vector
//   - idx_width(n) : bits needed to count 0..n, used for lane index and vec_count
package vector_pair_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEFAULT_W = 32;
  localparam int DEFAULT_N = 8;

  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vector_pair_packer_if.sv
// vector_pair_packer_if
//   Bundles the element input stream and the packed vector output stream.
//   Ports (signals):
//     in_valid/in_ready/in_a/in_b/in_last : element pair stream into the packer
//     vec_valid/vec_ready                 : packed pair handshake out of the packer
//     vector_a/vector_b                   : packed vectors, lane i at [W*i +: W]
//     vec_count                           : number of valid lanes in the presented pair
//   Modports:
//     master : environment side (upstream producer + downstream consumer)
//     slave  : packer side
interface vector_pair_packer_if #(
  parameter int N = 8,
  parameter int W = 32
);
  import vector_pair_packer_pkg::*;

  localparam int CW = idx_width(N);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_last;
  logic           vec_valid;
  logic           vec_ready;
  logic [W*N-1:0] vector_a;
  logic [W*N-1:0] vector_b;
  logic [CW-1:0]  vec_count;

  modport master (
    output in_valid, in_a, in_b, in_last, vec_ready,
    input  in_ready, vec_valid, vector_a, vector_b, vec_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, vec_ready,
    output in_ready, vec_valid, vector_a, vector_b, vec_count
  );

endinterface

// File: rtl/vector_pair_packer_lane_bank.sv
// vector_lane_bank
//   N x W register bank with one write port addressed by lane index and a
//   synchronous clear of all lanes. Contents are presented packed.
//   Ports:
//     clk, rst_n : clock and asynchronous active-low reset (clears all lanes)
//     clear      : synchronous clear of every lane, wins over a write
//     wr_en      : write wr_data into lane wr_idx on this edge
//     wr_idx     : lane index to write
//     wr_data    : element to store
//     data       : packed lanes, lane i at [W*i +: W]
module vector_lane_bank
  import vector_pair_packer_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [idx_width(N)-1:0]   wr_idx,
  input  logic [W-1:0]              wr_data,
  output logic [W*N-1:0]            data
);

  localparam int IW = idx_width(N);

  logic [W-1:0] lanes [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lanes[i] <= '0;
      end else if (clear) begin
        lanes[i] <= '0;
      end else if (wr_en && (wr_idx == IW'(i))) begin
        lanes[i] <= wr_data;
      end
    end

    assign data[W*i +: W] = lanes[i];
  end

endmodule

// File: rtl/vector_pair_packer.sv
// vector_pair_packer
//   Serial-to-packed front end: collects one (a,b) element pair per cycle
//   into two lane banks and presents the completed pair with valid/ready.
//   in_last closes a vector early; unused lanes stay zero because every
//   output transfer clears both banks.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous reset, active low
//     bus   : vector_pair_packer_if slave (element stream in, packed pair out)
module vector_pair_packer
  import vector_pair_packer_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vector_pair_packer_if.slave  bus
);

  localparam int IW = idx_width(N);

  state_t        state;
  state_t        next_state;
  logic [IW-1:0] idx;
  logic [IW-1:0] vec_count_q;
  logic          in_xfer;
  logic          out_xfer;
  logic          close_vec;

  // Handshake outputs come straight from the state register.
  assign bus.in_ready  = (state == FILL);
  assign bus.vec_valid = (state == HOLD);
  assign bus.vec_count = vec_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  // A vector closes on the last lane or on an explicit in_last, whichever comes first.
  always_comb begin
    next_state = state;
    in_xfer    = 1'b0;
    out_xfer   = 1'b0;
    close_vec  = 1'b0;
    case (state)
      FILL: begin
        in_xfer   = bus.in_valid;
        close_vec = in_xfer && (bus.in_last || (idx == IW'(N - 1)));
        if (close_vec) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        out_xfer = bus.vec_ready;
        if (out_xfer) begin
          next_state = FILL;
        end
      end
      default: begin
        next_state = FILL;
      end
    endcase
  end

  // Lane index and the lane count latched when the vector closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      vec_count_q <= '0;
    end else if (out_xfer) begin
      idx         <= '0;
      vec_count_q <= '0;
    end else if (in_xfer) begin
      idx <= idx + IW'(1);
      if (close_vec) begin
        vec_count_q <= idx + IW'(1);
      end
    end
  end

  vector_lane_bank #(.N(N), .W(W)) u_bank_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (out_xfer),
    .wr_en   (in_xfer),
    .wr_idx  (idx),
    .wr_data (bus.in_a),
    .data    (bus.vector_a)
  );

  vector_lane_bank #(.N(N), .W(W)) u_bank_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (out_xfer),
    .wr_en   (in_xfer),
    .wr_idx  (idx),
    .wr_data (bus.in_b),
    .data    (bus.vector_b)
  );

endmodule

// File: tb/tb_vector_pair_packer.sv
// tb_vector_pair_packer
//   Directed self-checking bench for vector_pair_packer with N=8, W=32.
//   Each scenario task drives its own stimulus and compares against
//   hand-computed constants.
module tb_vector_pair_packer;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int CW = $clog2(N + 1);

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  vector_pair_packer_if #(.N(N), .W(W)) bus ();

  vector_pair_packer #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream dot product of the presented pair, unsigned lanes.
  function automatic longint unsigned dot(input logic [W*N-1:0] a, input logic [W*N-1:0] b);
    longint unsigned acc;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      acc += longint'(a[W*i +: W]) * longint'(b[W*i +: W]);
    end
    return acc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one pair and returns once it is accepted; edges = clock edges taken.
  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic last,
                           output int edges);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    edges        = 0;
    while (1) begin
      logic accepted;
      accepted = bus.in_ready;
      step();
      edges++;
      if (accepted) break;
      if (edges > 50) begin
        $display("[TB] FAIL send_timeout: in_ready stuck low, got 0 required 1");
        failures++;
        checks++;
        break;
      end
    end
  endtask

  // One output transfer, then vec_ready drops again.
  task automatic release_pair();
    bus.in_valid  = 1'b0;
    bus.vec_ready = 1'b1;
    step();
    bus.vec_ready = 1'b0;
  endtask

  task automatic test_reset();
    int e;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.vec_valid !== 1'b0 || bus.vec_count !== '0 || bus.vector_a !== '0 || bus.vector_b !== '0) begin
      $display("[TB] FAIL reset_state: vec_valid=%0b vec_count=%0d a=%0h b=%0h required 0", bus.vec_valid, bus.vec_count, bus.vector_a, bus.vector_b);
      failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("[TB] FAIL reset_in_ready: got %0b required 1", bus.in_ready);
      failures++;
    end
    // Partial vector, then reset mid-stream.
    send_pair(32'h11, 32'h22, 1'b0, e);
    send_pair(32'h33, 32'h44, 1'b0, e);
    send_pair(32'h55, 32'h66, 1'b0, e);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.vector_a !== '0 || bus.vector_b !== '0 || bus.vec_count !== '0 || bus.vec_valid !== 1'b0) begin
      $display("[TB] FAIL reset_midstream: a=%0h b=%0h count=%0d valid=%0b required all 0", bus.vector_a, bus.vector_b, bus.vec_count, bus.vec_valid);
      failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("[TB] FAIL reset_midstream_ready: got %0b required 1", bus.in_ready);
      failures++;
    end
    // Index must have restarted at lane 0.
    send_pair(32'hAB, 32'hCD, 1'b1, e);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.vec_count !== CW'(1) || bus.vector_a !== {{(W*(N-1)){1'b0}}, 32'hAB} || bus.vector_b !== {{(W*(N-1)){1'b0}}, 32'hCD}) begin
      $display("[TB] FAIL reset_restart_lane0: count=%0d a=%0h b=%0h required count 1 lane0 ab/cd", bus.vec_count, bus.vector_a, bus.vector_b);
      failures++;
    end
    release_pair();
  endtask

  task automatic test_full_vector();
    int e;
    logic [W*N-1:0] exp_a;
    logic [W*N-1:0] exp_b;
    bus.vec_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp_a[W*i +: W] = W'(i + 1);
      exp_b[W*i +: W] = W'(10 * (i + 1));
      send_pair(W'(i + 1), W'(10 * (i + 1)), 1'b0, e);
      if (i < N - 1) begin
        checks++;
        if (bus.vec_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
          $display("[TB] FAIL full_fill_state lane %0d: vec_valid=%0b in_ready=%0b required 0/1", i, bus.vec_valid, bus.in_ready);
          failures++;
        end
      end
    end
    checks++;
    if (bus.vec_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      $display("[TB] FAIL full_hold_state: vec_valid=%0b in_ready=%0b required 1/0", bus.vec_valid, bus.in_ready);
      failures++;
    end
    checks++;
    if (bus.vector_a !== exp_a || bus.vector_b !== exp_b) begin
      $display("[TB] FAIL full_vectors: a=%0h b=%0h required a=%0h b=%0h", bus.vector_a, bus.vector_b, exp_a, exp_b);
      failures++;
    end
    checks++;
    if (bus.vec_count !== CW'(8)) begin
      $display("[TB] FAIL full_count: got %0d required 8", bus.vec_count);
      failures++;
    end
    checks++;
    if (dot(bus.vector_a, bus.vector_b) !== 64'd2040) begin
      $display("[TB] FAIL full_dot: got %0d required 2040", dot(bus.vector_a, bus.vector_b));
      failures++;
    end
    // Next element should see exactly one bubble: two edges to be accepted.
    send_pair(32'd9, 32'd90, 1'b0, e);
    checks++;
    if (e !== 2) begin
      $display("[TB] FAIL full_bubble: accepted after %0d edges required 2", e);
      failures++;
    end
    send_pair(32'd5, 32'd6, 1'b1, e);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.vec_count !== CW'(2) || bus.vector_a !== {{(W*(N-2)){1'b0}}, 32'd5, 32'd9} || bus.vector_b !== {{(W*(N-2)){1'b0}}, 32'd6, 32'd90}) begin
      $display("[TB] FAIL full_second: count=%0d a=%0h b=%0h required count 2 a=5,9 b=6,90", bus.vec_count, bus.vector_a, bus.vector_b);
      failures++;
    end
    step();
    bus.vec_ready = 1'b0;
    checks++;
    if (bus.vec_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.vector_a !== '0 || bus.vector_b !== '0 || bus.vec_count !== '0) begin
      $display("[TB] FAIL full_clear: valid=%0b ready=%0b a=%0h b=%0h count=%0d required 0/1/0/0/0", bus.vec_valid, bus.in_ready, bus.vector_a, bus.vector_b, bus.vec_count);
      failures++;
    end
  endtask

  // Leaves the packer in HOLD for the backpressure scenario.
  task automatic test_early_last();
    int e;
    bus.vec_ready = 1'b0;
    send_pair(32'd2, 32'd3, 1'b0, e);
    send_pair(32'd4, 32'd5, 1'b0, e);
    send_pair(32'd6, 32'd7, 1'b1, e);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.vec_valid !== 1'b1 || bus.vec_count !== CW'(3)) begin
      $display("[TB] FAIL early_count: valid=%0b count=%0d required 1/3", bus.vec_valid, bus.vec_count);
      failures++;
    end
    checks++;
    if (bus.vector_a[W*N-1:W*3] !== '0 || bus.vector_b[W*N-1:W*3] !== '0) begin
      $display("[TB] FAIL early_pad: a_hi=%0h b_hi=%0h required 0", bus.vector_a[W*N-1:W*3], bus.vector_b[W*N-1:W*3]);
      failures++;
    end
    checks++;
    if (dot(bus.vector_a, bus.vector_b) !== 64'd68) begin
      $display("[TB] FAIL early_dot: got %0d required 68", dot(bus.vector_a, bus.vector_b));
      failures++;
    end
  endtask

  task automatic test_backpressure();
    logic [W*N-1:0] snap_a;
    logic [W*N-1:0] snap_b;
    int bad;
    snap_a = {{(W*(N-3)){1'b0}}, 32'd6, 32'd4, 32'd2};
    snap_b = {{(W*(N-3)){1'b0}}, 32'd7, 32'd5, 32'd3};
    bad = 0;
    bus.vec_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      bus.in_last  = c[0];
      step();
      checks++;
      if (bus.in_ready !== 1'b0 || bus.vec_valid !== 1'b1 || bus.vector_a !== snap_a || bus.vector_b !== snap_b || bus.vec_count !== CW'(3)) begin
        if (bad < 3) begin
          $display("[TB] FAIL backpressure_hold cycle %0d: ready=%0b valid=%0b count=%0d a=%0h required ready 0 valid 1 count 3 a=%0h", c, bus.in_ready, bus.vec_valid, bus.vec_count, bus.vector_a, snap_a);
        end
        bad++;
        failures++;
      end
    end
    release_pair();
    checks++;
    if (bus.vec_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.vector_a !== '0 || bus.vector_b !== '0 || bus.vec_count !== '0) begin
      $display("[TB] FAIL backpressure_release: valid=%0b ready=%0b a=%0h b=%0h count=%0d required 0/1/0/0/0", bus.vec_valid, bus.in_ready, bus.vector_a, bus.vector_b, bus.vec_count);
      failures++;
    end
  endtask

  task automatic test_input_gaps();
    int e;
    logic [W*N-1:0] exp_a;
    logic [W*N-1:0] exp_b;
    bus.vec_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_last  = 1'b1;
        step();
      end
      exp_a[W*i +: W] = W'(32'h100 + i);
      exp_b[W*i +: W] = W'(32'h200 + i);
      send_pair(W'(32'h100 + i), W'(32'h200 + i), 1'b0, e);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.vec_valid !== 1'b1 || bus.vec_count !== CW'(8)) begin
      $display("[TB] FAIL gaps_count: valid=%0b count=%0d required 1/8", bus.vec_valid, bus.vec_count);
      failures++;
    end
    checks++;
    if (bus.vector_a !== exp_a || bus.vector_b !== exp_b) begin
      $display("[TB] FAIL gaps_vectors: a=%0h b=%0h required a=%0h b=%0h", bus.vector_a, bus.vector_b, exp_a, exp_b);
      failures++;
    end
    release_pair();
  endtask

  task automatic test_clear_after_short();
    int e;
    logic [W*N-1:0] exp_a;
    logic [W*N-1:0] exp_b;
    bus.vec_ready = 1'b0;
    send_pair(32'd7, 32'd8, 1'b0, e);
    send_pair(32'd9, 32'd10, 1'b1, e);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.vec_count !== CW'(2) || bus.vector_a !== {{(W*(N-2)){1'b0}}, 32'd9, 32'd7}) begin
      $display("[TB] FAIL short_vector: count=%0d a=%0h required count 2 a=9,7", bus.vec_count, bus.vector_a);
      failures++;
    end
    release_pair();
    // Last element flagged in_last on lane N-1: same as a full vector.
    for (int i = 0; i < N; i++) begin
      exp_a[W*i +: W] = W'(32'hA0 + i);
      exp_b[W*i +: W] = W'(32'hB0 + i);
      send_pair(W'(32'hA0 + i), W'(32'hB0 + i), (i == N - 1), e);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.vec_count !== CW'(8) || bus.vector_a !== exp_a || bus.vector_b !== exp_b) begin
      $display("[TB] FAIL short_then_full: count=%0d a=%0h b=%0h required count 8 a=%0h b=%0h", bus.vec_count, bus.vector_a, bus.vector_b, exp_a, exp_b);
      failures++;
    end
    release_pair();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.vec_ready = 1'b0;
    rst_n         = 1'b1;
    test_reset();
    test_full_vector();
    test_early_last();
    test_backpressure();
    test_input_gaps();
    test_clear_after_short();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
